key_schedule_ctrl: RTL and testbench

- Parametrised controller for the round-key generator in the block-cipher datapath. It drives the PC-1 load mux, the C/D rotate amount and direction, and the per-round subkey write enable.
- Supports a configurable round count and shift schedule, and both encrypt (rotate left) and decrypt (rotate right) key order.
- Uses a start/busy/done handshake with abort, replacing the free-running counter-driven controller.

---
 rtl/key_schedule_ctrl.sv | 116 +++++++++++
 tb/tb_key_schedule_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
// Round-key generator controller: sequences PC-1 load, per-round C/D rotate
// amount/direction and subkey write enable under a start/busy/done handshake.
module key_schedule_ctrl #(
    parameter int                ROUNDS     = 16,
    parameter int                CNT_W      = 5,
    parameter logic [ROUNDS-1:0] SHIFT_MASK = 16'h7EFC
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Mode,
    input  logic             Abort,
    output logic             Busy,
    output logic             Done,
    output logic             Load_key,
    output logic             Round_valid,
    output logic [CNT_W-1:0] Round,
    output logic [1:0]       Shift_amt,
    output logic             Shift_dir
);

    if (ROUNDS < 1 || ROUNDS > (1 << CNT_W) - 1) begin : g_bad_rounds
        $error("key_schedule_ctrl: ROUNDS out of range for CNT_W");
    end

    // Mask padded to the full counter range so any counter value indexes it.
    localparam int             MW       = 1 << CNT_W;
    localparam logic [MW-1:0]  MASK_EXT = MW'(SHIFT_MASK);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] enc_idx, dec_idx;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (Start && !Abort) begin
                    state_d = S_LOAD;
                    mode_d  = Mode;
                end
            end
            S_LOAD: begin
                if (Abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = S_ROUND;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_ROUND: begin
                if (Abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(ROUNDS)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // Back-to-back: a start in DONE goes straight to LOAD.
                if (Start && !Abort) begin
                    state_d = S_LOAD;
                    mode_d  = Mode;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Decrypt walks the encrypt schedule backwards, offset by one round since
    // C16 = C0 makes its first round a zero rotate.
    assign enc_idx = cnt_q - CNT_W'(1);
    assign dec_idx = CNT_W'(ROUNDS + 1) - cnt_q;

    always_comb begin
        Busy        = (state_q == S_LOAD) || (state_q == S_ROUND);
        Done        = (state_q == S_DONE);
        Load_key    = (state_q == S_LOAD);
        Round_valid = (state_q == S_ROUND);
        Round       = '0;
        Shift_amt   = 2'd0;
        Shift_dir   = Busy & mode_q;
        if (state_q == S_ROUND) begin
            Round = cnt_q;
            if (!mode_q)
                Shift_amt = MASK_EXT[enc_idx] ? 2'd2 : 2'd1;
            else if (cnt_q == CNT_W'(1))
                Shift_amt = 2'd0;
            else
                Shift_amt = MASK_EXT[dec_idx] ? 2'd2 : 2'd1;
        end
    end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Randomized self-checking bench for key_schedule_ctrl: default 16-round DES
// instance plus an 8-round variant, both checked against a timeline model.
module tb_key_schedule_ctrl;

    logic Clk, Reset_n, Start, Mode, Abort;

    logic       a_busy, a_done, a_load, a_rv, a_dir;
    logic [4:0] a_round;
    logic [1:0] a_amt;
    logic       b_busy, b_done, b_load, b_rv, b_dir;
    logic [3:0] b_round;
    logic [1:0] b_amt;

    int vectors = 0;
    int errors  = 0;

    key_schedule_ctrl dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Mode(Mode), .Abort(Abort),
        .Busy(a_busy), .Done(a_done), .Load_key(a_load), .Round_valid(a_rv),
        .Round(a_round), .Shift_amt(a_amt), .Shift_dir(a_dir)
    );

    key_schedule_ctrl #(.ROUNDS(8), .CNT_W(4), .SHIFT_MASK(8'h81)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Mode(Mode), .Abort(Abort),
        .Busy(b_busy), .Done(b_done), .Load_key(b_load), .Round_valid(b_rv),
        .Round(b_round), .Shift_amt(b_amt), .Shift_dir(b_dir)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Packed view: {busy, done, load, rv, round[4:0], amt[1:0], dir}
    function automatic logic [11:0] get_obs(input bit sel);
        if (sel) return {b_busy, b_done, b_load, b_rv, 1'b0, b_round, b_amt, b_dir};
        return {a_busy, a_done, a_load, a_rv, a_round, a_amt, a_dir};
    endfunction

    function automatic int rounds_of(input bit sel);
        return sel ? 8 : 16;
    endfunction

    function automatic logic [1:0] exp_shift(input bit sel, input bit mode, input int r);
        logic [15:0] mask;
        int          n;
        mask = sel ? 16'h0081 : 16'h7EFC;
        n    = rounds_of(sel);
        if (!mode) return mask[r-1] ? 2'd2 : 2'd1;
        if (r == 1) return 2'd0;
        return mask[n+1-r] ? 2'd2 : 2'd1;
    endfunction

    // Expected outputs k cycles after the edge that accepted Start.
    function automatic logic [11:0] exp_out(input bit sel, input bit mode, input int k);
        int n;
        n = rounds_of(sel);
        if (k == 1) return {1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0, mode};
        if (k >= 2 && k <= n + 1)
            return {1'b1, 1'b0, 1'b0, 1'b1, 5'(k-1), exp_shift(sel, mode, k-1), mode};
        if (k == n + 2) return 12'h400;
        return 12'h000;
    endfunction

    task automatic settle();
        Start = 1'b0;
        Abort = 1'b0;
        repeat (20) @(negedge Clk);
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        Reset_n = 1'b0; Start = 1'b0; Mode = 1'b0; Abort = 1'b0;
        repeat (3) @(negedge Clk);
        for (int s = 0; s < 2; s++) begin
            obs = get_obs(s[0]);
            vectors++;
            if (obs !== 12'h000) begin
                errors++;
                $display("FAIL reset_outputs dut=%0d got %h want %h", s, obs, 12'h000);
            end
        end
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        obs = get_obs(1'b0);
        vectors++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL idle_after_reset got %h want %h", obs, 12'h000);
        end
    endtask

    task automatic test_schedule(input bit sel, input bit mode);
        logic [11:0] obs, exp;
        int n, sum, done_k, want_sum;
        n = rounds_of(sel);
        sum = 0; done_k = -1;
        want_sum = sel ? (mode ? 8 : 10) : (mode ? 27 : 28);
        settle();
        Start = 1'b1; Mode = mode;
        @(negedge Clk);
        for (int k = 1; k <= n + 4; k++) begin
            obs = get_obs(sel);
            exp = exp_out(sel, mode, k);
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL sched sel=%0d mode=%0d k=%0d got %h want %h", sel, mode, k, obs, exp);
            end
            if (obs[8] === 1'b1) sum += int'(obs[2:1]);
            if (obs[10] === 1'b1 && done_k < 0) done_k = k;
            // Start/Mode noise while busy must be ignored.
            Start = (k <= n + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            Mode  = 1'($urandom);
            @(negedge Clk);
        end
        vectors++;
        if (sum !== want_sum) begin
            errors++;
            $display("FAIL shift_sum sel=%0d mode=%0d got %0d want %0d", sel, mode, sum, want_sum);
        end
        vectors++;
        if (done_k !== n + 2) begin
            errors++;
            $display("FAIL done_latency sel=%0d got %0d want %0d", sel, done_k, n + 2);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] obs, exp;
        bit m [4];
        m[0] = 1'($urandom);
        for (int s = 1; s < 4; s++) m[s] = ~m[s-1];
        settle();
        Start = 1'b1; Mode = m[0];
        @(negedge Clk);
        for (int s = 0; s < 3; s++) begin
            for (int k = 1; k <= 18; k++) begin
                obs = get_obs(1'b0);
                exp = exp_out(1'b0, m[s], k);
                vectors++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL b2b sched=%0d k=%0d got %h want %h", s, k, obs, exp);
                end
                if (k == 18) begin
                    Mode  = m[s+1];
                    Start = (s < 2);
                end else begin
                    Mode = 1'($urandom);
                end
                @(negedge Clk);
            end
        end
        obs = get_obs(1'b0);
        vectors++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL b2b_release got %h want %h", obs, 12'h000);
        end
    endtask

    task automatic test_abort(input int ar);
        logic [11:0] obs, exp;
        bit md;
        md = 1'($urandom);
        settle();
        Start = 1'b1; Mode = md;
        @(negedge Clk);
        Start = 1'b0;
        for (int k = 1; k <= ar + 1; k++) begin
            obs = get_obs(1'b0);
            exp = exp_out(1'b0, md, k);
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL abort_pre ar=%0d k=%0d got %h want %h", ar, k, obs, exp);
            end
            if (k == ar + 1) begin
                Abort = 1'b1;
                Start = 1'($urandom);
            end
            @(negedge Clk);
        end
        Abort = 1'b0; Start = 1'b0;
        for (int j = 0; j < 20; j++) begin
            obs = get_obs(1'b0);
            vectors++;
            if (obs !== 12'h000) begin
                errors++;
                $display("FAIL abort_post ar=%0d j=%0d got %h want %h", ar, j, obs, 12'h000);
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_abort_edges();
        logic [11:0] obs, exp;
        settle();
        // Abort with Start in IDLE: rejected.
        Start = 1'b1; Abort = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Abort = 1'b0;
        obs = get_obs(1'b0);
        vectors++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL abort_idle got %h want %h", obs, 12'h000);
        end
        // Abort with Start in DONE: Done still shows, restart rejected.
        Start = 1'b1; Mode = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            obs = get_obs(1'b0);
            exp = exp_out(1'b0, 1'b0, k);
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL abort_done k=%0d got %h want %h", k, obs, exp);
            end
            Start = (k == 18); Abort = (k == 18); Mode = 1'($urandom);
            @(negedge Clk);
        end
        Start = 1'b0; Abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [11:0] obs, exp;
        settle();
        Start = 1'b1; Mode = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            obs = get_obs(1'b0);
            exp = exp_out(1'b0, 1'b1, k);
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rstmid_pre k=%0d got %h want %h", k, obs, exp);
            end
            if (k < 10) @(negedge Clk);
        end
        #2 Reset_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            obs = get_obs(s[0]);
            vectors++;
            if (obs !== 12'h000) begin
                errors++;
                $display("FAIL rstmid_async dut=%0d got %h want %h", s, obs, 12'h000);
            end
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge Clk);
            obs = get_obs(1'b0);
            vectors++;
            if (obs !== 12'h000) begin
                errors++;
                $display("FAIL rstmid_idle j=%0d got %h want %h", j, obs, 12'h000);
            end
        end
    endtask

    initial begin
        test_reset();
        test_schedule(1'b0, 1'b0);
        test_schedule(1'b0, 1'b1);
        test_back_to_back();
        test_abort(5);
        test_schedule(1'b0, 1'($urandom));
        test_abort($urandom_range(1, 16));
        test_abort_edges();
        test_reset_mid();
        test_schedule(1'b0, 1'($urandom));
        test_schedule(1'b1, 1'b0);
        test_schedule(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) test_schedule(1'($urandom), 1'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
